// File: rtl/instr_fetch_queue.sv
// rtl/instr_fetch_queue.sv - instruction fetch queue: 1-cycle memory read, DEPTH-entry FIFO, valid/ready to decode
// Optional feature macro: IFQ_STALL_CNT_EN (adds stall_cnt output counting back-pressured fetch requests)
module instr_fetch_queue #(
  parameter int AWIDTH = 6,
  parameter int RWIDTH = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [AWIDTH-1:0] addr_in,
  input  logic              addr_valid,
  output logic              addr_ready,
  input  logic              flush,
  output logic              mem_en,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic [RWIDTH-1:0] mem_rdata,
`ifdef IFQ_STALL_CNT_EN
  output logic [15:0]       stall_cnt,
`endif
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [RWIDTH-1:0] instr,
  output logic [AWIDTH-1:0] instr_addr
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic              inflight;
  logic [AWIDTH-1:0] inflight_addr;
  logic [RWIDTH-1:0] data_mem [DEPTH];
  logic [AWIDTH-1:0] addr_mem [DEPTH];
  logic [RWIDTH-1:0] last_instr;
  logic [AWIDTH-1:0] last_addr;
  logic [CW:0]       credit_used;
  logic              accept;
  logic              push;
  logic              pop;

  // Queued entries plus the read still in flight must leave room, so a returning word always has a slot.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign addr_ready  = !flush && (credit_used < (CW+1)'(DEPTH));
  assign accept      = addr_valid && addr_ready;
  assign mem_en      = accept;
  assign mem_addr    = addr_in;

  // A flush drops the word returning this cycle and ignores any pop, since the queue is cleared anyway.
  assign push        = inflight && !flush;
  assign instr_valid = (count != '0);
  assign pop         = instr_valid && instr_ready && !flush;

  // When empty the outputs keep the last head seen, so decode never sees stale slot contents or X.
  assign instr       = instr_valid ? data_mem[rd_ptr] : last_instr;
  assign instr_addr  = instr_valid ? addr_mem[rd_ptr] : last_addr;

  // Track the single outstanding memory read and the address it was issued for.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight      <= 1'b0;
      inflight_addr <= '0;
    end else begin
      inflight      <= accept;
      inflight_addr <= addr_in;
    end
  end

  // Queue pointers and occupancy; push and pop in the same cycle leave count unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(push);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage: returning word is written at the tail together with its fetch address.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= mem_rdata;
      addr_mem[wr_ptr] <= inflight_addr;
    end
  end

  // Remember the current head every cycle the queue is non-empty, to present it once the queue drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_instr <= '0;
      last_addr  <= '0;
    end else if (instr_valid) begin
      last_instr <= data_mem[rd_ptr];
      last_addr  <= addr_mem[rd_ptr];
    end
  end

`ifdef IFQ_STALL_CNT_EN
  // Count cycles where the PC block wanted to fetch but had no credit; saturating, cleared on redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (flush) begin
      stall_cnt <= '0;
    end else if (addr_valid && !addr_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb/tb_instr_fetch_queue.sv - directed self-checking bench for instr_fetch_queue (optional IFQ_STALL_CNT_EN)
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [5:0]  addr_in;
  logic        addr_valid;
  logic        addr_ready;
  logic        flush;
  logic        mem_en;
  logic [5:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [5:0]  instr_addr;
`ifdef IFQ_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int failures = 0;

  instr_fetch_queue #(.AWIDTH(6), .RWIDTH(32), .DEPTH(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .addr_in(addr_in),
    .addr_valid(addr_valid),
    .addr_ready(addr_ready),
    .flush(flush),
    .mem_en(mem_en),
    .mem_addr(mem_addr),
    .mem_rdata(mem_rdata),
`ifdef IFQ_STALL_CNT_EN
    .stall_cnt(stall_cnt),
`endif
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_addr(instr_addr)
  );

  always #5 clk = ~clk;

  // Instruction memory: synchronous read, word = zero-extended address.
  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (mem_en) mem_rdata <= {26'h0, mem_addr};
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; addr_valid = 1'b0; addr_in = 6'd0; flush = 1'b0; instr_ready = 1'b0;

    // Reset state
    step(); step(); #2;
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_instr_addr", 64'(instr_addr), 64'd0);
    chk("rst_mem_en", 64'(mem_en), 64'd0);
    rst_n = 1'b1; #2;
    chk("rst_addr_ready", 64'(addr_ready), 64'd1);

    // Stream addr 0..7, decode always ready: head appears 2 cycles after accept, no gaps
    for (int t = 0; t <= 10; t++) begin
      step();
      addr_valid = (t < 8); addr_in = 6'(t); instr_ready = 1'b1;
      #2;
      if (t < 8) begin
        chk("stream_addr_ready", 64'(addr_ready), 64'd1);
        chk("stream_mem_addr", 64'(mem_addr), 64'(t));
      end
      chk("stream_valid", 64'(instr_valid), 64'((t >= 2) && (t < 10)));
      if ((t >= 2) && (t < 10)) begin
        chk("stream_instr_addr", 64'(instr_addr), 64'(t - 2));
        chk("stream_instr", 64'(instr), 64'(t - 2));
      end
    end

    // Back-pressure: 10..13 accepted, 14 stalled until decode drains
    for (int c = 0; c <= 14; c++) begin
      step();
      instr_ready = (c >= 9); addr_valid = (c <= 10); addr_in = (c < 4) ? 6'(10 + c) : 6'd14;
      #2;
      if (c <= 10) chk("bp_addr_ready", 64'(addr_ready), 64'((c < 4) || (c == 10)));
      chk("bp_valid", 64'(instr_valid), 64'((c >= 2) && (c <= 13)));
      if ((c >= 2) && (c <= 13))
        chk("bp_instr_addr", 64'(instr_addr), 64'((c <= 9) ? 10 : c + 1));
`ifdef IFQ_STALL_CNT_EN
      if (c == 9) chk("bp_stall_cnt", 64'(stall_cnt), 64'd5);
`endif
    end

    // Full credit: 3 queued + 1 in flight, push and pop together, order kept
    for (int c = 0; c <= 8; c++) begin
      step();
      instr_ready = (c >= 4); addr_valid = (c < 4); addr_in = 6'(30 + c);
      #2;
      if (c <= 5) chk("full_addr_ready", 64'(addr_ready), 64'(c != 4));
      chk("full_valid", 64'(instr_valid), 64'((c >= 2) && (c <= 7)));
      if ((c >= 2) && (c <= 7))
        chk("full_instr_addr", 64'(instr_addr), 64'((c <= 4) ? 30 : c + 26));
    end

    // Flush with 3 queued and addr 20 in flight; then addr 40 refetched
    for (int c = 0; c <= 8; c++) begin
      step();
      addr_valid = (c <= 4) || (c == 6);
      addr_in = (c < 4) ? 6'(17 + c) : ((c == 4) ? 6'd21 : 6'd40);
      flush = (c == 4); instr_ready = (c == 4);
      #2;
      if (c <= 3) chk("fl_addr_ready", 64'(addr_ready), 64'd1);
      if (c == 4) begin
        chk("fl_ready_low", 64'(addr_ready), 64'd0);
        chk("fl_mem_en_low", 64'(mem_en), 64'd0);
        chk("fl_valid_during", 64'(instr_valid), 64'd1);
        chk("fl_head_during", 64'(instr_addr), 64'd17);
      end
      if ((c >= 5) && (c <= 7)) chk("fl_valid_after", 64'(instr_valid), 64'd0);
      if (c == 5) begin
        chk("fl_hold_instr", 64'(instr), 64'd17);
        chk("fl_ready_after", 64'(addr_ready), 64'd1);
`ifdef IFQ_STALL_CNT_EN
        chk("fl_stall_clr", 64'(stall_cnt), 64'd0);
`endif
      end
      if (c == 6) chk("fl_refetch_en", 64'(mem_en), 64'd1);
      if (c == 8) begin
        chk("fl_new_valid", 64'(instr_valid), 64'd1);
        chk("fl_new_instr", 64'(instr), 64'h28);
        chk("fl_new_addr", 64'(instr_addr), 64'd40);
      end
    end

    // Reset mid-operation: 40 and 50 queued, 51 in flight
    instr_ready = 1'b0; flush = 1'b0;
    step(); addr_valid = 1'b1; addr_in = 6'd50;
    step(); addr_valid = 1'b1; addr_in = 6'd51;
    step(); addr_valid = 1'b0; #2;
    chk("mid_valid_pre", 64'(instr_valid), 64'd1);
    rst_n = 1'b0; #1;
    chk("mid_rst_valid", 64'(instr_valid), 64'd0);
    chk("mid_rst_instr", 64'(instr), 64'd0);
    chk("mid_rst_addr", 64'(instr_addr), 64'd0);
    step(); rst_n = 1'b1; #2;
    chk("mid_rel_ready", 64'(addr_ready), 64'd1);
    chk("mid_rel_valid", 64'(instr_valid), 64'd0);
    step(); #2;
    chk("mid_no_late_push", 64'(instr_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
